// File: rtl/muxn_reg.sv
// muxn_reg: N-channel registered mux with manual select, round-robin scan of valid channels and hold
module muxn_reg #(
   parameter int N = 4,
   parameter int W = 8,
   localparam int SW = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N*W-1:0] in_data,
   input  logic [N-1:0]   in_valid,
   input  logic [SW-1:0]  sel,
   input  logic           mode,
   input  logic           hold,
   output logic [W-1:0]   out_data,
   output logic           out_valid,
   output logic [SW-1:0]  out_ch
);
   logic [W-1:0]   data_q, data_d, man_data, rr_data;
   logic           valid_q, valid_d, man_valid, found;
   logic [SW-1:0]  ch_q, ch_d, ptr_q, ptr_d, off, gnt;
   logic [SW:0]    sum;
   logic [2*N-1:0] rot;
   // doubled vector shifted so bit j is channel (ptr+1+j) mod N
   assign rot = {in_valid, in_valid} >> ({1'b0, ptr_q} + 1'b1);
   always_comb begin
      found = 1'b0;
      off = '0;
      for (int j = N - 1; j >= 0; j--) begin
         if (rot[j]) begin
            found = 1'b1;
            off = SW'(j);
         end
      end
   end
   assign sum = {1'b0, ptr_q} + {1'b0, off} + 1'b1;
   assign gnt = sum >= (SW+1)'(N) ? SW'(sum - (SW+1)'(N)) : SW'(sum);
   always_comb begin
      man_data = '0;
      man_valid = 1'b0;
      rr_data = '0;
      for (int k = 0; k < N; k++) begin
         if (sel == SW'(k)) begin
            man_data = in_data[k*W +: W];
            man_valid = in_valid[k];
         end
         if (gnt == SW'(k)) rr_data = in_data[k*W +: W];
      end
   end
   always_comb begin
      data_d = hold ? data_q : mode ? (found ? rr_data : data_q) : man_data;
      valid_d = hold ? valid_q : mode ? found : man_valid;
      ch_d = hold ? ch_q : mode ? (found ? gnt : ch_q) : sel;
      ptr_d = (!hold && mode && found) ? gnt : ptr_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
         valid_q <= 1'b0;
         ch_q <= '0;
         ptr_q <= SW'(N - 1);
      end else begin
         data_q <= data_d;
         valid_q <= valid_d;
         ch_q <= ch_d;
         ptr_q <= ptr_d;
      end
   end
   assign out_data = data_q;
   assign out_valid = valid_q;
   assign out_ch = ch_q;
endmodule

// File: tb/tb_muxn_reg.sv
// tb_muxn_reg: directed checks of muxn_reg at N=4/W=8 and N=3/W=4
module tb_muxn_reg;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] in_data = '0;
   logic [3:0]  in_valid = '0;
   logic [1:0]  sel = '0;
   logic        mode = 1'b0;
   logic        hold = 1'b0;
   logic [7:0]  out_data;
   logic        out_valid;
   logic [1:0]  out_ch;
   logic [11:0] in_data3 = 12'hCBA;
   logic [2:0]  in_valid3 = 3'b111;
   logic [1:0]  sel3 = '0;
   logic        mode3 = 1'b0;
   logic [3:0]  out_data3;
   logic        out_valid3;
   logic [1:0]  out_ch3;
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   muxn_reg #(.N(4), .W(8)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .sel(sel),
      .mode(mode), .hold(hold), .out_data(out_data), .out_valid(out_valid), .out_ch(out_ch)
   );

   muxn_reg #(.N(3), .W(4)) dut3 (
      .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3), .sel(sel3),
      .mode(mode3), .hold(1'b0), .out_data(out_data3), .out_valid(out_valid3), .out_ch(out_ch3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk4(input string tag, input logic [7:0] d, input logic v, input logic [1:0] c);
      chk({tag, ".data"}, 32'(out_data), 32'(d));
      chk({tag, ".valid"}, 32'(out_valid), 32'(v));
      chk({tag, ".ch"}, 32'(out_ch), 32'(c));
   endtask

   task automatic reset_pulse();
      #2 rst = 1'b1;
      #2 rst = 1'b0;
   endtask

   initial begin
      #3;
      chk4("reset", 8'h00, 1'b0, 2'd0);
      chk("reset3.valid", 32'(out_valid3), 32'd0);
      in_data = 32'h44332211;
      in_valid = 4'b1111;
      rst = 1'b0;
      // manual sweep
      sel = 2'd0; step(); chk4("man0", 8'h11, 1'b1, 2'd0);
      sel = 2'd1; step(); chk4("man1", 8'h22, 1'b1, 2'd1);
      sel = 2'd2; step(); chk4("man2", 8'h33, 1'b1, 2'd2);
      sel = 2'd3; step(); chk4("man3", 8'h44, 1'b1, 2'd3);
      in_valid = 4'b0111;
      step(); chk4("man3_inv", 8'h44, 1'b0, 2'd3);
      // round-robin, all valid
      in_valid = 4'b1111;
      reset_pulse();
      mode = 1'b1;
      step(); chk4("rr_a0", 8'h11, 1'b1, 2'd0);
      step(); chk4("rr_a1", 8'h22, 1'b1, 2'd1);
      step(); chk4("rr_a2", 8'h33, 1'b1, 2'd2);
      step(); chk4("rr_a3", 8'h44, 1'b1, 2'd3);
      step(); chk4("rr_a4", 8'h11, 1'b1, 2'd0);
      step(); chk4("rr_a5", 8'h22, 1'b1, 2'd1);
      // sparse, none, single
      reset_pulse();
      in_valid = 4'b1010;
      step(); chk4("sp0", 8'h22, 1'b1, 2'd1);
      step(); chk4("sp1", 8'h44, 1'b1, 2'd3);
      step(); chk4("sp2", 8'h22, 1'b1, 2'd1);
      step(); chk4("sp3", 8'h44, 1'b1, 2'd3);
      in_valid = 4'b0000;
      in_data = 32'h99887766;
      step(); chk4("none", 8'h44, 1'b0, 2'd3);
      in_data = 32'h44332211;
      in_valid = 4'b1000;
      step(); chk4("one0", 8'h44, 1'b1, 2'd3);
      step(); chk4("one1", 8'h44, 1'b1, 2'd3);
      in_valid = 4'b0100;
      step(); chk4("wrap2", 8'h33, 1'b1, 2'd2);
      // hold freezes everything including ptr
      reset_pulse();
      in_valid = 4'b1111;
      step(); chk4("h_pre0", 8'h11, 1'b1, 2'd0);
      step(); chk4("h_pre1", 8'h22, 1'b1, 2'd1);
      hold = 1'b1;
      mode = 1'b0;
      sel = 2'd3;
      in_data = 32'hDDCCBBAA;
      in_valid = 4'b0101;
      step(); chk4("hold0", 8'h22, 1'b1, 2'd1);
      mode = 1'b1;
      step(); chk4("hold1", 8'h22, 1'b1, 2'd1);
      in_valid = 4'b0000;
      step(); chk4("hold2", 8'h22, 1'b1, 2'd1);
      hold = 1'b0;
      in_data = 32'h44332211;
      in_valid = 4'b1111;
      step(); chk4("h_post", 8'h33, 1'b1, 2'd2);
      // asynchronous reset between edges
      #2 rst = 1'b1;
      #1 chk4("async_rst", 8'h00, 1'b0, 2'd0);
      #2 rst = 1'b0;
      step(); chk4("rst_first", 8'h11, 1'b1, 2'd0);
      // N=3: out-of-range select, then in-range, then RR wrap
      sel3 = 2'd3;
      step();
      chk("oor.valid", 32'(out_valid3), 32'd0);
      chk("oor.data", 32'(out_data3), 32'd0);
      chk("oor.ch", 32'(out_ch3), 32'd3);
      sel3 = 2'd2;
      step();
      chk("n3sel2.valid", 32'(out_valid3), 32'd1);
      chk("n3sel2.data", 32'(out_data3), 32'hC);
      chk("n3sel2.ch", 32'(out_ch3), 32'd2);
      reset_pulse();
      mode3 = 1'b1;
      step(); chk("n3rr0.ch", 32'(out_ch3), 32'd0);
      step(); chk("n3rr1.ch", 32'(out_ch3), 32'd1);
      step(); chk("n3rr2.ch", 32'(out_ch3), 32'd2);
      step();
      chk("n3rr3.ch", 32'(out_ch3), 32'd0);
      chk("n3rr3.data", 32'(out_data3), 32'hA);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
